// File: rtl/ram_request_sequencer_if.sv
// ---------------------------------------------------------------------------
// ram_request_sequencer_if
//   Request/acknowledge port between the RAM request sequencer and the
//   shared memory controller.
//
//   Signals:
//     MEM_REQ     request valid (held until MEM_ACK)
//     MEM_WE      1 = write, 0 = read
//     MEM_RFSH    refresh request (address/data not meaningful)
//     MEM_ADDR    word address (host byte address without bit 0)
//     MEM_WDATA   write data, 8-bit writes replicated on both lanes
//     MEM_BE      byte enables {hi, lo}
//     MEM_ACK     request accepted
//     MEM_RVALID  one-cycle read-data-valid pulse
//     MEM_RDATA   read data
//
//   Modports: master = sequencer side, slave = memory controller side.
// ---------------------------------------------------------------------------
interface ram_request_sequencer_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                  MEM_REQ;
    logic                  MEM_WE;
    logic                  MEM_RFSH;
    logic [ADDR_WIDTH-2:0] MEM_ADDR;
    logic [15:0]           MEM_WDATA;
    logic [1:0]            MEM_BE;
    logic                  MEM_ACK;
    logic                  MEM_RVALID;
    logic [15:0]           MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_RFSH, MEM_ADDR, MEM_WDATA, MEM_BE,
        input  MEM_ACK, MEM_RVALID, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_RFSH, MEM_ADDR, MEM_WDATA, MEM_BE,
        output MEM_ACK, MEM_RVALID, MEM_RDATA
    );
endinterface

// File: rtl/ram_request_sequencer.sv
// ---------------------------------------------------------------------------
// ram_request_sequencer
//   Turns the level-style host RAM strobes (OE_n / WE_n / RFSH_n) into
//   single-shot requests for the shared memory controller. Each strobe
//   assertion yields exactly one transaction regardless of its length.
//
//   Ports:
//     CLK, RESET_n  clock, asynchronous active-low reset
//     ADDR          host byte address
//     DIN           host write data
//     DIN_SIZE      0 = 8-bit access, 1 = 16-bit access
//     OE_n, WE_n    host read / write strobes (level, active low)
//     RFSH_n        host refresh strobe (level, active low)
//     DOUT          host read data
//     BUSY          high whenever the sequencer is not idle
//     mem           memory controller request/ack port (master side)
// ---------------------------------------------------------------------------
module ram_request_sequencer #(
    parameter int ADDR_WIDTH    = 22,
    parameter bit USE_READ_HOLD = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESET_n,
    input  logic [ADDR_WIDTH-1:0]   ADDR,
    input  logic [15:0]             DIN,
    input  logic                    DIN_SIZE,
    input  logic                    OE_n,
    input  logic                    WE_n,
    input  logic                    RFSH_n,
    output logic [15:0]             DOUT,
    output logic                    BUSY,
    ram_request_sequencer_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        RF_REQ,
        RELEASE
    } state_t;

    state_t state, state_d;

    logic                  oe_q, we_q, rfsh_q;
    logic                  oe_edge, we_edge, rfsh_edge;
    logic                  oe_go, we_go;
    logic                  latch;
    logic                  host_done;
    logic                  rf_pending;
    logic [ADDR_WIDTH-2:0] req_addr;
    logic [15:0]           req_wdata;
    logic [1:0]            req_be;
    logic                  req_size;
    logic                  req_odd;
    logic [15:0]           dout_q;

    // Strobes are already in the CLK domain; an edge is "was high, now low".
    assign oe_edge   = oe_q   & ~OE_n;
    assign we_edge   = we_q   & ~WE_n;
    assign rfsh_edge = rfsh_q & ~RFSH_n;

    // A strobe still held low after its transaction completed is ignored.
    assign we_go = (we_edge | ~WE_n) & ~host_done;
    assign oe_go = (oe_edge | ~OE_n) & ~host_done;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                // Write beats read beats refresh; a simultaneous read is dropped.
                if (we_go) begin
                    state_d = WR_REQ;
                    latch   = 1'b1;
                end else if (oe_go) begin
                    state_d = RD_REQ;
                    latch   = 1'b1;
                end else if (rf_pending) begin
                    state_d = RF_REQ;
                end
            end
            RD_REQ: begin
                if (mem.MEM_ACK) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (mem.MEM_RVALID) state_d = RELEASE;
            end
            WR_REQ: begin
                if (mem.MEM_ACK) state_d = RELEASE;
            end
            RF_REQ: begin
                if (mem.MEM_ACK) state_d = (OE_n && WE_n) ? IDLE : RELEASE;
            end
            RELEASE: begin
                if (OE_n && WE_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            rfsh_q     <= 1'b1;
            host_done  <= 1'b0;
            rf_pending <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_be     <= '0;
            req_size   <= 1'b0;
            req_odd    <= 1'b0;
            dout_q     <= '0;
        end else begin
            oe_q   <= OE_n;
            we_q   <= WE_n;
            rfsh_q <= RFSH_n;

            // Only one refresh can be outstanding; extra edges are absorbed.
            if (state == RF_REQ && mem.MEM_ACK) begin
                rf_pending <= 1'b0;
            end else if (rfsh_edge) begin
                rf_pending <= 1'b1;
            end

            if (state == RELEASE) begin
                host_done <= ~(OE_n & WE_n);
            end

            if (latch) begin
                req_addr  <= ADDR[ADDR_WIDTH-1:1];
                req_size  <= DIN_SIZE;
                req_odd   <= ADDR[0];
                req_be    <= DIN_SIZE ? 2'b11 : {ADDR[0], ~ADDR[0]};
                req_wdata <= DIN_SIZE ? DIN : {DIN[7:0], DIN[7:0]};
            end

            if (state == RD_DATA && mem.MEM_RVALID) begin
                if (req_size) begin
                    dout_q <= mem.MEM_RDATA;
                end else begin
                    dout_q <= {8'h00, req_odd ? mem.MEM_RDATA[15:8] : mem.MEM_RDATA[7:0]};
                end
            end
        end
    end

    assign mem.MEM_REQ   = (state == RD_REQ) || (state == WR_REQ) || (state == RF_REQ);
    assign mem.MEM_WE    = (state == WR_REQ);
    assign mem.MEM_RFSH  = (state == RF_REQ);
    assign mem.MEM_ADDR  = req_addr;
    assign mem.MEM_WDATA = req_wdata;
    assign mem.MEM_BE    = req_be;

    assign DOUT = (USE_READ_HOLD || !OE_n) ? dout_q : '0;
    assign BUSY = (state != IDLE);

endmodule

// File: doc/ram_request_sequencer.md
# ram_request_sequencer

Converts the level-style host RAM port driven by the cartridge controllers into single-shot requests for the shared memory controller. Each falling edge of OE_n or WE_n becomes exactly one read or write transaction, and each refresh strobe becomes one refresh request. It sits directly downstream of the PAC ROM controller, on the Ram interface device side, and directly upstream of the memory controller's request/ack port.

## Interface

Parameters:
- ADDR_WIDTH, 22: host byte-address width.
- USE_READ_HOLD, 1: when 1, DOUT holds the last read data until the next read completes. When 0, DOUT is forced to 0 while OE_n is high.

Ports:
- CLK, in, 1: system clock, the only clock.
- RESET_n, in, 1: asynchronous, active-low reset.
- ADDR, in, ADDR_WIDTH: host byte address.
- DIN, in, 16: host write data.
- DIN_SIZE, in, 1: 0 selects 8-bit, 1 selects 16-bit.
- OE_n, in, 1: host read strobe, level.
- WE_n, in, 1: host write strobe, level.
- RFSH_n, in, 1: host refresh strobe, level.
- DOUT, out, 16: host read data.
- MEM_REQ, out, 1: request valid.
- MEM_WE, out, 1: 1 means write, 0 means read.
- MEM_RFSH, out, 1: refresh request (no address or data).
- MEM_ADDR, out, ADDR_WIDTH-1: word address, equal to ADDR[ADDR_WIDTH-1:1].
- MEM_WDATA, out, 16: write data.
- MEM_BE, out, 2: byte enables.
- MEM_ACK, in, 1: request accepted.
- MEM_RVALID, in, 1: one-cycle read-data-valid pulse.
- MEM_RDATA, in, 16: read data.
- BUSY, out, 1: high in any state other than IDLE.

## Operation

- States:
  - IDLE
  - RD_REQ and RD_DATA
  - WR_REQ
  - RF_REQ
  - RELEASE
- Strobe detection: OE_n, WE_n and RFSH_n are registered each cycle. An edge is the registered value being 1 while the current value is 0.
  - Inputs share the CLK domain, so no synchronizer is used.
- IDLE:
  - Priority is WE_n edge or WE_n low, then OE_n edge or OE_n low, then pending refresh.
  - On an access, latch ADDR, DIN and DIN_SIZE into the request registers, then go to WR_REQ or RD_REQ.
  - A strobe that is still low in IDLE but was already serviced (host-done flag set) is ignored.
- Byte lanes:
  - For 16-bit access, MEM_BE = 2'b11 and MEM_WDATA = DIN.
  - For 8-bit access, MEM_BE = {ADDR[0], ~ADDR[0]}, and MEM_WDATA places DIN[7:0] in both byte lanes.
- RD_REQ / WR_REQ / RF_REQ: MEM_REQ=1 with all fields stable until MEM_ACK=1 is seen in the same cycle.
  - On that ACK, WR_REQ and RF_REQ go to RELEASE (RF_REQ goes to IDLE if no host strobe is low).
  - On that ACK, RD_REQ goes to RD_DATA.
- RD_DATA: wait for MEM_RVALID.
  - For 16-bit reads, DOUT = MEM_RDATA.
  - For 8-bit reads, DOUT = {8'h00, selected byte}, where ADDR[0]=1 selects MEM_RDATA[15:8].
  - Then go to RELEASE.
- RELEASE:
  - Set the host-done flag. Wait until OE_n and WE_n are both high, then clear the flag and go to IDLE.
  - One transaction per strobe assertion, regardless of strobe length.
- Refresh:
  - An RFSH_n edge sets rf_pending in any state.
  - A second edge while the flag is already set is absorbed and does not queue.
  - RF_REQ clears rf_pending on ACK.
  - Refresh is issued from IDLE only, and only when no host strobe is newly asserted.
- Simultaneous OE_n and WE_n falling: the write is serviced and the read is dropped (host protocol violation).
- Reset:
  - DOUT=0, MEM_REQ=0, MEM_WE=0, MEM_RFSH=0, MEM_ADDR=0, MEM_WDATA=0, MEM_BE=0, BUSY=0.
  - State=IDLE, rf_pending=0, host-done=0, strobe registers=1.
  - Reset mid-transaction abandons the request immediately. The memory controller must tolerate MEM_REQ dropping before ACK.

## Timing

- Strobe edge visible at cycle N, so MEM_REQ is registered high at N+1.
- Write: with MEM_ACK at N+1, MEM_REQ is low at N+2 and the state is RELEASE.
- Read: with ACK at N+1 and RVALID at N+1+L, DOUT is valid at N+2+L.
- Refresh pending with no host access: MEM_REQ with MEM_RFSH=1 rises one cycle after IDLE is entered.
- MEM_REQ never deasserts without ACK, except on reset.
- MEM_REQ is always low for at least one cycle between requests.
- MEM_WE and MEM_RFSH are 0 whenever MEM_REQ=0.

## Test plan

- Write, 8-bit at odd address: ADDR=0x2001, DIN=0x00A5, DIN_SIZE=0, WE_n low for 10 cycles, ACK after 3 cycles.
  - Exactly one request: MEM_ADDR=0x1000, MEM_WE=1, MEM_BE=2'b10, MEM_WDATA=0xA5A5.
- Read, 16-bit: ADDR=0x0400, OE_n low, RDATA=0x1234 with RVALID 4 cycles after ACK.
  - DOUT=0x1234 one cycle after RVALID.
  - No second request while OE_n is held low for 20 cycles.
- Read, 8-bit at odd address: RDATA=0xBEEF at ADDR=0x0401.
  - DOUT=0x00BE.
  - USE_READ_HOLD=0: DOUT=0 once OE_n rises.
- Refresh collision: RFSH_n edge while a read is in RD_DATA, plus a second RFSH_n edge.
  - Exactly one MEM_RFSH request, issued after RELEASE→IDLE.
  - rf_pending cleared on its ACK.
- Priority: OE_n and WE_n fall in the same cycle while rf_pending=1.
  - Write issued first, then refresh, no read.
- Reset mid-read: RESET_n low during RD_DATA.
  - All outputs at reset values within the same cycle. BUSY=0.
  - The next OE_n edge produces a normal read.
